// File: rtl/mmio_bridge.sv
// Data-memory bridge: passes RAM traffic through and maps a small
// peripheral block (buttons, LEDs, countdown timer) into one MMIO page.
module mmio_bridge #(
  parameter int          NUM_BTN         = 4,
  parameter int          NUM_LED         = 4,
  parameter logic [19:0] MMIO_BASE       = 20'h00001,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wren,
  input  logic [31:0]        address_dmem,
  input  logic [31:0]        data,
  output logic [31:0]        q_dmem,
  output logic               ram_wEn,
  output logic [11:0]        ram_addr,
  output logic [31:0]        ram_dataIn,
  input  logic [31:0]        ram_dataOut,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [NUM_LED-1:0] leds,
  output logic               timer_done
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_MMIO
  } src_e;

  logic sel_ram;
  logic sel_mmio;
  logic reg_hit;
  logic [2:0] offset;

  assign sel_ram  = address_dmem[31:12] == 20'd0;
  assign sel_mmio = address_dmem[31:12] == MMIO_BASE;
  assign reg_hit  = sel_mmio && (address_dmem[11:3] == 9'd0);
  assign offset   = address_dmem[2:0];

  assign ram_addr   = address_dmem[11:0];
  assign ram_dataIn = data;
  assign ram_wEn    = wren & sel_ram;

  logic wr_event;
  logic wr_led;
  logic wr_timer;
  logic wr_done;

  always_comb begin
    wr_event = 1'b0;
    wr_led   = 1'b0;
    wr_timer = 1'b0;
    wr_done  = 1'b0;
    if (wren && reg_hit) begin
      unique case (offset)
        3'd1:    wr_event = 1'b1;
        3'd2:    wr_led   = 1'b1;
        3'd3:    wr_timer = 1'b1;
        3'd4:    wr_done  = 1'b1;
        default: ;
      endcase
    end
  end

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_next;
  logic [NUM_BTN-1:0] events;
  logic [NUM_BTN-1:0] events_next;
  logic [CW-1:0]      cnt      [NUM_BTN];
  logic [CW-1:0]      cnt_next [NUM_BTN];

  always_comb begin
    level_next = level;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != level[i]) begin
        cnt_next[i] = cnt[i] + 1'b1;
        if (cnt_next[i] == CNT_MAX) begin
          level_next[i] = sync2[i];
          cnt_next[i]   = '0;
        end
      end
    end
  end

  // Rising edges of the debounced level win over a same-cycle W1C.
  always_comb begin
    events_next = events;
    if (wr_event) events_next = events & ~data[NUM_BTN-1:0];
    events_next = events_next | (level_next & ~level);
  end

  logic [NUM_LED-1:0] led_reg;
  logic [31:0]        timer;
  logic               done;
  logic               done_set;

  assign done_set = !wr_timer && (timer == 32'd1);

  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    if (reg_hit) begin
      unique case (offset)
        3'd0:    mmio_rdata = 32'(level);
        3'd1:    mmio_rdata = 32'(events);
        3'd2:    mmio_rdata = 32'(led_reg);
        3'd3:    mmio_rdata = timer;
        3'd4:    mmio_rdata = {31'd0, done};
        default: mmio_rdata = '0;
      endcase
    end
  end

  src_e        rd_src;
  logic [31:0] rd_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      events  <= '0;
      led_reg <= '0;
      timer   <= '0;
      done    <= 1'b0;
      rd_src  <= SRC_NONE;
      rd_val  <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1  <= buttons;
      sync2  <= sync1;
      level  <= level_next;
      events <= events_next;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= cnt_next[i];
      if (wr_led) led_reg <= data[NUM_LED-1:0];
      if (wr_timer) timer <= data;
      else if (timer != 32'd0) timer <= timer - 32'd1;
      if (done_set) done <= 1'b1;
      else if (wr_done) done <= 1'b0;
      rd_src <= sel_ram ? SRC_RAM : (sel_mmio ? SRC_MMIO : SRC_NONE);
      rd_val <= mmio_rdata;
    end
  end

  always_comb begin
    unique case (rd_src)
      SRC_RAM:  q_dmem = ram_dataOut;
      SRC_MMIO: q_dmem = rd_val;
      default:  q_dmem = '0;
    endcase
  end

  assign leds       = led_reg;
  assign timer_done = done;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a behavioural one-cycle RAM.
// Inputs change and outputs are sampled on the falling edge.
module tb_mmio_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut = '0;
  logic [3:0]  buttons = '0;
  logic [3:0]  leds;
  logic        timer_done;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [4096];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  mmio_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_dmem       (q_dmem),
    .ram_wEn      (ram_wEn),
    .ram_addr     (ram_addr),
    .ram_dataIn   (ram_dataIn),
    .ram_dataOut  (ram_dataOut),
    .buttons      (buttons),
    .leds         (leds),
    .timer_done   (timer_done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle();
    wren = 1'b0;
    address_dmem = 32'h0;
    data = 32'h0;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    wren = 1'b1;
    address_dmem = a;
    data = d;
    tick();
    idle();
  endtask

  task automatic lw(input logic [31:0] a, input string tag,
                    input logic [31:0] exp);
    wren = 1'b0;
    address_dmem = a;
    tick();
    check(tag, q_dmem, exp);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    tick(2);
    check("rst_q", q_dmem, 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_done", 32'(timer_done), 32'h0);
    reset = 1'b1;
    tick();

    // RAM pass-through
    wren = 1'b1;
    address_dmem = 32'h5;
    data = 32'h1234;
    #1;
    check("ram_wen_hi", 32'(ram_wEn), 32'h1);
    check("ram_addr", 32'(ram_addr), 32'h5);
    tick();
    idle();
    #1;
    check("ram_wen_lo", 32'(ram_wEn), 32'h0);
    tick();
    lw(32'h5, "ram_rd", 32'h1234);
    check("leds_still0", 32'(leds), 32'h0);

    // LED register
    wren = 1'b1;
    address_dmem = 32'h1002;
    data = 32'hFFFF_FFFF;
    #1;
    check("led_no_ramwen", 32'(ram_wEn), 32'h0);
    tick();
    idle();
    check("leds_f", 32'(leds), 32'hF);
    lw(32'h1002, "led_rd", 32'hF);

    // Debounce and events
    buttons[2] = 1'b1;
    tick(20);
    lw(32'h1000, "lvl_b2", 32'h4);
    lw(32'h1001, "evt_b2", 32'h4);
    buttons[0] = 1'b1;
    tick(10);
    buttons[0] = 1'b0;
    tick(20);
    lw(32'h1000, "lvl_glitch", 32'h4);
    lw(32'h1001, "evt_glitch", 32'h4);
    sw(32'h1001, 32'h4);
    lw(32'h1001, "evt_w1c", 32'h0);
    buttons[2] = 1'b0;
    tick(25);
    lw(32'h1000, "lvl_fall", 32'h0);
    lw(32'h1001, "evt_fall", 32'h0);

    // Unmapped offsets and pages
    sw(32'h1005, 32'hDEAD);
    lw(32'h1005, "off5", 32'h0);
    lw(32'h100A, "hi_off", 32'h0);

    // Countdown 3,2,1,0
    sw(32'h1003, 32'h3);
    address_dmem = 32'h1003;
    tick();
    check("tmr3", q_dmem, 32'h3);
    check("done_a", 32'(timer_done), 32'h0);
    tick();
    check("tmr2", q_dmem, 32'h2);
    check("done_b", 32'(timer_done), 32'h0);
    tick();
    check("tmr1", q_dmem, 32'h1);
    check("done_rise", 32'(timer_done), 32'h1);
    tick();
    check("tmr0", q_dmem, 32'h0);
    lw(32'h1004, "done_rd", 32'h1);
    sw(32'h1004, 32'h0);
    check("done_clr", 32'(timer_done), 32'h0);

    // Reload on the 1->0 cycle suppresses done
    sw(32'h1003, 32'h2);
    tick();
    sw(32'h1003, 32'h5);
    check("reload_done", 32'(timer_done), 32'h0);
    lw(32'h1003, "reload_cnt", 32'h5);
    tick(6);
    check("reload_end", 32'(timer_done), 32'h1);
    sw(32'h1004, 32'h0);

    // Done set beats a same-cycle clear
    sw(32'h1003, 32'h2);
    tick();
    sw(32'h1004, 32'h0);
    check("set_wins", 32'(timer_done), 32'h1);

    // Load of zero does not set done
    sw(32'h1004, 32'h0);
    sw(32'h1003, 32'h0);
    tick();
    check("load0", 32'(timer_done), 32'h0);

    // Async reset with live state
    sw(32'h1003, 32'd100);
    sw(32'h1002, 32'hA);
    buttons[1] = 1'b1;
    tick(20);
    lw(32'h1001, "pre_evt", 32'h2);
    address_dmem = 32'h1002;
    tick();
    check("pre_q", q_dmem, 32'hA);
    buttons[1] = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_q", q_dmem, 32'h0);
    check("arst_leds", 32'(leds), 32'h0);
    check("arst_done", 32'(timer_done), 32'h0);
    idle();
    tick(2);
    reset = 1'b1;
    tick();
    lw(32'h1003, "post_tmr", 32'h0);
    lw(32'h1001, "post_evt", 32'h0);
    lw(32'h1002, "post_led", 32'h0);
    lw(32'h2000, "unmapped", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
